// File: rtl/store_buffer.sv
// store_buffer: small FIFO of pending stores sitting in front of DataMemory.
// Stores are queued and drained one per cycle whenever the memory port is not
// claimed by a load. Loads read memory combinationally and pick up the
// youngest matching buffered store (store-to-load forwarding).
// Optional feature macro: STB_COALESCE_EN -- a store that hits an already
// buffered address overwrites that entry in place instead of allocating.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_store,
  input  logic                    cpu_load,
  input  logic                    cpu_fence,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [$clog2(DEPTH):0]  sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage. Only the valid bits are reset; payload is don't-care
  // while its valid bit is clear.
  logic [ADDR_W-1:0] addr_reg  [DEPTH];
  logic [DATA_W-1:0] data_reg  [DEPTH];
  logic              valid_reg [DEPTH];

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              full;
  logic              nonempty;
  logic              drain;
  logic              coalesce_hit;
  logic              store_accept;
  logic              do_alloc;

  logic [DEPTH-1:0]  match_vec;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign nonempty = (count_reg != '0);

  // The single memory port goes to a load when one is requested; otherwise
  // the head entry is written out. Pop happens at the following posedge.
  assign drain = !cpu_load && nonempty;

  // Per-entry address comparators, shared by forwarding and coalescing.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_vec[gi] = valid_reg[gi] && (addr_reg[gi] == cpu_addr);
    end
  endgenerate

  // Forwarding: walk from oldest (head) to youngest so the last hit wins.
  // An entry draining this cycle is still valid here, which is intended.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (match_vec[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_reg[fwd_idx];
      end
    end
  end

`ifdef STB_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;
  logic             coal_match;
  logic             do_update;

  // Locate the (at most one) entry holding cpu_addr. A hit on the head that
  // is leaving this cycle is not usable, so such a store allocates instead.
  always_comb begin
    coal_match = 1'b0;
    coal_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_vec[k]) begin
        coal_match = 1'b1;
        coal_idx   = PTR_W'(k);
      end
    end
  end

  assign coalesce_hit = coal_match && !(drain && (coal_idx == head_reg));
  assign do_update    = store_accept && coalesce_hit;
`else
  assign coalesce_hit = 1'b0;
`endif

  // A store only gets in while there is room now; an entry freed by this
  // cycle's drain becomes usable next cycle. A stalled store is retried by
  // the core, so it must not be enqueued.
  assign cpu_stall    = (cpu_store && full && !coalesce_hit) ||
                        (cpu_fence && nonempty);
  assign store_accept = cpu_store && !cpu_stall;
  assign do_alloc     = store_accept && !coalesce_hit;

  // Memory port arbitration and load result.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = data_reg[head_reg];
    if (drain) begin
      mem_we   = 1'b1;
      mem_addr = addr_reg[head_reg];
    end
  end

  assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;
  assign sb_count  = count_reg;

  // Entry array: pop clears the head valid bit, allocation fills the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_reg[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (drain && (head_reg == PTR_W'(k))) begin
          valid_reg[k] <= 1'b0;
        end
        if (do_alloc && (tail_reg == PTR_W'(k))) begin
          valid_reg[k] <= 1'b1;
          addr_reg[k]  <= cpu_addr;
          data_reg[k]  <= cpu_wdata;
        end
`ifdef STB_COALESCE_EN
        if (do_update && (coal_idx == PTR_W'(k))) begin
          data_reg[k] <= cpu_wdata;
        end
`endif
      end
    end
  end

  // Head/tail pointers wrap naturally (DEPTH is a power of two); occupancy
  // is unchanged when an allocation and a drain coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PTR_W'(drain);
      tail_reg  <= tail_reg + PTR_W'(do_alloc);
      count_reg <= count_reg + CNT_W'(do_alloc) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model of the store buffer.
// Honours STB_COALESCE_EN for the coalescing-specific sequences and model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_store;
  logic        cpu_load;
  logic        cpu_fence;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [2:0]  sb_count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_store(cpu_store), .cpu_load(cpu_load), .cpu_fence(cpu_fence),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  // DataMemory: async read, negedge write
  logic [15:0] dmem [256];
  assign mem_rdata = dmem[mem_addr];
  always @(negedge clk) begin
    if (mem_we) dmem[mem_addr] = mem_wdata;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic l, input logic f,
                      input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r; cpu_store = s; cpu_load = l; cpu_fence = f; cpu_addr = a; cpu_wdata = d;
    #3;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic r, s, l, f;
    logic [7:0]  a;
    logic [15:0] d;
    logic        c;      // check this row
    logic        es, ew; // expected stall, mem_we
    logic [7:0]  ema;    // expected mem_addr (checked if write or load)
    logic [2:0]  ec;     // expected sb_count
    logic        cr;     // check rdata
    logic [15:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic l, logic f, logic [7:0] a,
                              logic [15:0] d, logic c, logic es, logic ew,
                              logic [7:0] ema, logic [2:0] ec, logic cr, logic [15:0] er);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.f = f; v.a = a; v.d = d; v.c = c;
    v.es = es; v.ew = ew; v.ema = ema; v.ec = ec; v.cr = cr; v.er = er;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  logic [15:0] refmem [256];

  task automatic model_cycle(input logic r, input logic s, input logic l, input logic f,
                             input logic [7:0] a, input logic [15:0] d);
    bit          drn, fl, hit, e_stall;
    int          hidx;
    logic [15:0] e_rd;
    logic [7:0]  e_ma;
    ent_t        e;
    step(r, s, l, f, a, d);
    drn  = !l && (q.size() > 0);
    fl   = (q.size() == DEPTH);
    hit  = 1'b0;
    hidx = -1;
`ifdef STB_COALESCE_EN
    foreach (q[j]) if (q[j].addr == a) hidx = j;
    hit = (hidx >= 0) && !(hidx == 0 && drn);
`endif
    e_stall = (s && fl && !hit) || (f && q.size() != 0);
    e_rd = refmem[a];
    foreach (q[j]) if (q[j].addr == a) e_rd = q[j].data;
    e_ma = l ? a : ((q.size() > 0) ? q[0].addr : a);
    chk("rnd_stall", 16'(cpu_stall), 16'(e_stall));
    chk("rnd_we", 16'(mem_we), 16'(drn));
    chk("rnd_count", 16'(sb_count), 16'(q.size()));
    chk("rnd_maddr", 16'(mem_addr), 16'(e_ma));
    if (drn) chk("rnd_wdata", mem_wdata, q[0].data);
    if (l) chk("rnd_rdata", cpu_rdata, e_rd);
    $display("rnd rst=%0b st=%0b ld=%0b fn=%0b addr=%02h wd=%04h | stall=%0b we=%0b cnt=%0d rd=%04h",
             r, s, l, f, a, d, cpu_stall, mem_we, sb_count, cpu_rdata);
    // state update for the coming posedge
    if (drn) begin
      refmem[q[0].addr] = q[0].data;
      void'(q.pop_front());
    end
    if (r) begin
      q.delete();
    end else if (s && !e_stall) begin
      if (hit) begin
        hidx = drn ? hidx - 1 : hidx;
        e = q[hidx];
        e.data = d;
        q[hidx] = e;
      end else begin
        e.addr = a;
        e.data = d;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic        rr, s, l, f;
    logic [7:0]  a;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) begin
      dmem[i]   = 16'h0000;
      refmem[i] = 16'h0000;
    end
    rst = 1'b1; cpu_store = 1'b0; cpu_load = 1'b0; cpu_fence = 1'b0;
    cpu_addr = 8'h00; cpu_wdata = 16'h0000;

    //            r s l f addr   wdata     c es ew ema   ec cr rd
    tbl.push_back(mk(1,0,0,0,8'h00,16'h0000,0,0,0,8'h00,0,0,16'h0000));
    tbl.push_back(mk(1,0,0,0,8'h00,16'h0000,1,0,0,8'h00,0,0,16'h0000)); // reset state
    // single store then drain
    tbl.push_back(mk(0,1,0,0,8'h10,16'hABCD,1,0,0,8'h00,0,0,16'h0000));
    tbl.push_back(mk(0,0,0,0,8'h00,16'h0000,1,0,1,8'h10,1,0,16'h0000));
    tbl.push_back(mk(0,0,1,0,8'h10,16'h0000,1,0,0,8'h10,0,1,16'hABCD));
    // fill under a held load, full-stall, then drain
    tbl.push_back(mk(0,1,1,0,8'h30,16'h0001,1,0,0,8'h30,0,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h31,16'h0002,1,0,0,8'h31,1,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h32,16'h0003,1,0,0,8'h32,2,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h33,16'h0004,1,0,0,8'h33,3,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h34,16'h0005,1,1,0,8'h34,4,1,16'h0000));
    tbl.push_back(mk(0,1,0,0,8'h34,16'h0005,1,1,1,8'h30,4,0,16'h0000));
    tbl.push_back(mk(0,1,0,0,8'h34,16'h0005,1,0,1,8'h31,3,0,16'h0000));
    tbl.push_back(mk(0,0,0,0,8'h00,16'h0000,1,0,1,8'h32,3,0,16'h0000));
    tbl.push_back(mk(0,0,0,0,8'h00,16'h0000,1,0,1,8'h33,2,0,16'h0000));
    tbl.push_back(mk(0,0,0,0,8'h00,16'h0000,1,0,1,8'h34,1,0,16'h0000));
    tbl.push_back(mk(0,0,1,0,8'h34,16'h0000,1,0,0,8'h34,0,1,16'h0005));
    tbl.push_back(mk(0,0,1,0,8'h30,16'h0000,1,0,0,8'h30,0,1,16'h0001));
    // fence drains 3 entries, stall exactly 3 cycles
    tbl.push_back(mk(0,1,1,0,8'h40,16'h00A1,1,0,0,8'h40,0,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h41,16'h00A2,1,0,0,8'h41,1,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h42,16'h00A3,1,0,0,8'h42,2,1,16'h0000));
    tbl.push_back(mk(0,0,0,1,8'h00,16'h0000,1,1,1,8'h40,3,0,16'h0000));
    tbl.push_back(mk(0,0,0,1,8'h00,16'h0000,1,1,1,8'h41,2,0,16'h0000));
    tbl.push_back(mk(0,0,0,1,8'h00,16'h0000,1,1,1,8'h42,1,0,16'h0000));
    tbl.push_back(mk(0,0,0,1,8'h00,16'h0000,1,0,0,8'h00,0,0,16'h0000));
    tbl.push_back(mk(0,0,1,0,8'h40,16'h0000,1,0,0,8'h40,0,1,16'h00A1));
    tbl.push_back(mk(0,0,1,0,8'h42,16'h0000,1,0,0,8'h42,0,1,16'h00A3));
    // reset with 3 buffered: in-flight write lands, rest lost
    tbl.push_back(mk(0,1,1,0,8'h50,16'h00B1,1,0,0,8'h50,0,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h51,16'h00B2,1,0,0,8'h51,1,1,16'h0000));
    tbl.push_back(mk(0,1,1,0,8'h52,16'h00B3,1,0,0,8'h52,2,1,16'h0000));
    tbl.push_back(mk(1,0,0,0,8'h00,16'h0000,1,0,1,8'h50,3,0,16'h0000));
    tbl.push_back(mk(0,0,0,0,8'h00,16'h0000,1,0,0,8'h00,0,0,16'h0000));
    tbl.push_back(mk(0,0,1,0,8'h50,16'h0000,1,0,0,8'h50,0,1,16'h00B1));
    tbl.push_back(mk(0,0,1,0,8'h51,16'h0000,1,0,0,8'h51,0,1,16'h0000));
    tbl.push_back(mk(0,0,1,0,8'h52,16'h0000,1,0,0,8'h52,0,1,16'h0000));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].f, tbl[i].a, tbl[i].d);
      if (tbl[i].c) begin
        chk($sformatf("row%0d_stall", i), 16'(cpu_stall), 16'(tbl[i].es));
        chk($sformatf("row%0d_we", i), 16'(mem_we), 16'(tbl[i].ew));
        chk($sformatf("row%0d_count", i), 16'(sb_count), 16'(tbl[i].ec));
        if (tbl[i].ew || tbl[i].l)
          chk($sformatf("row%0d_maddr", i), 16'(mem_addr), 16'(tbl[i].ema));
        if (tbl[i].cr)
          chk($sformatf("row%0d_rdata", i), cpu_rdata, tbl[i].er);
      end
      $display("row %0d rst=%0b st=%0b ld=%0b fn=%0b addr=%02h wd=%04h | stall=%0b we=%0b maddr=%02h cnt=%0d rd=%04h",
               i, tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].f, tbl[i].a, tbl[i].d,
               cpu_stall, mem_we, mem_addr, sb_count, cpu_rdata);
    end
    chk("mem_0x10", dmem[8'h10], 16'hABCD);
    chk("mem_0x41", dmem[8'h41], 16'h00A2);

`ifndef STB_COALESCE_EN
    // duplicate addresses coexist; youngest forwards
    step(0, 1, 1, 0, 8'h20, 16'h1111);
    step(0, 1, 1, 0, 8'h20, 16'h2222);
    chk("fwd_same_cycle_store", cpu_rdata, 16'h1111);
    step(0, 0, 1, 0, 8'h20, 16'h0000);
    chk("fwd_youngest", cpu_rdata, 16'h2222);
    chk("fwd_count", 16'(sb_count), 16'd2);
    chk("fwd_mem_untouched", dmem[8'h20], 16'h0000);
    $display("seq fwd rd=%04h cnt=%0d", cpu_rdata, sb_count);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("dup_drain1", mem_wdata, 16'h1111);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("dup_drain2", mem_wdata, 16'h2222);
    step(0, 0, 1, 0, 8'h20, 16'h0000);
    chk("dup_final_rd", cpu_rdata, 16'h2222);
    chk("dup_final_count", 16'(sb_count), 16'd0);
    $display("seq dup rd=%04h cnt=%0d", cpu_rdata, sb_count);
`else
    // full buffer, store hitting entry 2 coalesces without stalling
    step(0, 1, 1, 0, 8'h70, 16'h00C0);
    step(0, 1, 1, 0, 8'h71, 16'h00C1);
    step(0, 1, 1, 0, 8'h72, 16'h00C2);
    step(0, 1, 1, 0, 8'h73, 16'h00C3);
    step(0, 1, 1, 0, 8'h72, 16'h00CC);
    chk("coal_stall", 16'(cpu_stall), 16'd0);
    chk("coal_count_full", 16'(sb_count), 16'd4);
    step(0, 0, 1, 0, 8'h72, 16'h0000);
    chk("coal_count_kept", 16'(sb_count), 16'd4);
    chk("coal_fwd", cpu_rdata, 16'h00CC);
    $display("seq coal rd=%04h cnt=%0d", cpu_rdata, sb_count);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("coal_d0", mem_wdata, 16'h00C0);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("coal_d1", mem_wdata, 16'h00C1);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("coal_d2", mem_wdata, 16'h00CC);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("coal_d3", mem_wdata, 16'h00C3);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    chk("coal_empty", 16'(sb_count), 16'd0);
    chk("coal_mem", dmem[8'h72], 16'h00CC);
`endif

    // randomized run against the reference model on a fresh address window
    step(1, 0, 0, 0, 8'h00, 16'h0000);
    q.delete();
    for (int n = 0; n < 1000; n++) begin
      rr = ($urandom_range(0, 99) < 2);
      s  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 9) < 4);
      f  = !s && ($urandom_range(0, 9) == 0);
      a  = 8'h60 + 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      model_cycle(rr, s, l, f, a, d);
    end
    for (int n = 0; n < 6; n++) model_cycle(0, 0, 0, 0, 8'h60, 16'h0000);
    for (int i = 8'h60; i < 8'h68; i++) begin
      chk($sformatf("final_mem_%02h", i), dmem[i], refmem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
